// File: rtl/cpu_datapath.sv
// Single-cycle execute/writeback datapath: 32x32 register file, combinational ALU, writeback every clock.
// Define CPU_DATAPATH_DUMP_EN to compile in the simulation-only register dump task.
module cpu_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op,
  input  logic [4:0]  dst,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        has_immediate,
  input  logic [11:0] imm,
  output logic [31:0] out
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  logic [31:0] regs [32];
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;

  // r0 is forced to zero on the read side so it is valid even before the first reset.
  always_comb begin
    operand_a = (src1 == '0) ? '0 : regs[src1];
    if (has_immediate)
      operand_b = {{20{imm[11]}}, imm};
    else
      operand_b = (src2 == '0) ? '0 : regs[src2];
    shamt = operand_b[4:0];
  end

  always_comb begin
    out = '0;
    case (op)
      ALU_ADD:  out = operand_a + operand_b;
      ALU_SUB:  out = operand_a - operand_b;
      ALU_AND:  out = operand_a & operand_b;
      ALU_OR:   out = operand_a | operand_b;
      ALU_XOR:  out = operand_a ^ operand_b;
      ALU_SLL:  out = operand_a << shamt;
      ALU_SRL:  out = operand_a >> shamt;
      ALU_SRA:  out = $signed(operand_a) >>> shamt;
      ALU_SLT:  out = {31'b0, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: out = {31'b0, operand_a < operand_b};
      default:  out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (dst != '0) begin
      regs[dst] <= out;
    end
  end

`ifdef CPU_DATAPATH_DUMP_EN
  task automatic dump();
    for (int unsigned i = 1; i < 32; i++)
      $display("  r%0d: %0d", i, regs[i]);
  endtask
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed test-plan sequences plus randomized ops
// checked against an arithmetic reference model of the register file and ALU.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [4:0]  dst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        has_immediate;
  logic [11:0] imm;
  logic [31:0] out;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  logic [31:0] mreg [32];

  cpu_datapath dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .dst           (dst),
    .src1          (src1),
    .src2          (src2),
    .has_immediate (has_immediate),
    .imm           (imm),
    .out           (out)
  );

  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sext12(input logic [11:0] v);
    int s;
    s = int'(v);
    if (s >= 2048) s = s - 4096;
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_alu(input int unsigned o, input logic [31:0] a, input logic [31:0] b);
    longint unsigned pw;
    longint sa;
    longint q;
    longint unsigned p;
    int unsigned sh;
    sh = b % 32;
    pw = 1;
    for (int unsigned k = 0; k < sh; k++) pw = pw * 2;
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: begin p = longint'(a) * pw; return p[31:0]; end
      6: return 32'(longint'(a) / pw);
      7: begin
        sa = longint'(int'(a));
        q  = sa / longint'(pw);
        if (sa < 0 && (sa % longint'(pw)) != 0) q = q - 1;
        return q[31:0];
      end
      8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
  endtask

  // Present one op for a full cycle; check out mid-cycle, then retire it into the model at the edge.
  task automatic run_op(input string tag, input int unsigned o, input int unsigned d, input int unsigned s1,
                        input int unsigned s2, input logic hi, input logic [11:0] im, input logic rst,
                        output logic [31:0] res);
    logic [31:0] b;
    logic [31:0] exp;
    @(negedge clk);
    rst_n = ~rst; op = 4'(o); dst = 5'(d); src1 = 5'(s1); src2 = 5'(s2);
    has_immediate = hi; imm = im;
    #1;
    b   = hi ? sext12(im) : mreg[s2];
    exp = ref_alu(o, mreg[s1], b);
    res = out;
    check(tag, out, exp);
    @(posedge clk);
    if (rst) model_reset();
    else if (d != 0) mreg[d] = exp;
  endtask

  task automatic read_reg(input string tag, input int unsigned r, input logic [31:0] exp);
    @(negedge clk);
    rst_n = 1'b1; op = 4'd0; dst = 5'd0; src1 = 5'(r); src2 = 5'd0;
    has_immediate = 1'b1; imm = 12'd0;
    #1;
    check(tag, out, exp);
  endtask

  task automatic check_all_regs(input string tag);
    for (int unsigned r = 1; r < 32; r++) read_reg(tag, r, mreg[r]);
  endtask

  initial begin
    logic [31:0] res;
    int unsigned ro, rd, rs1, rs2;
    logic rhi, rrst;
    logic [11:0] rim;

    rst_n = 1'b0; op = 4'd0; dst = 5'd0; src1 = 5'd0; src2 = 5'd0;
    has_immediate = 1'b0; imm = 12'd0;
    repeat (2) @(posedge clk);
    model_reset();
    check_all_regs("reset_state");

    // Dependent chain, one op per cycle
    run_op("chain_r1a", 0, 1, 0, 0, 1'b1, 12'd10, 1'b0, res);
    check("chain_r1a_out", res, 32'd10);
    run_op("chain_r1b", 0, 1, 1, 0, 1'b1, 12'd40, 1'b0, res);
    run_op("chain_r2",  0, 2, 1, 0, 1'b1, 12'd10, 1'b0, res);
    run_op("chain_r3",  0, 3, 2, 0, 1'b1, 12'd1,  1'b0, res);
    run_op("chain_r4",  0, 4, 3, 0, 1'b1, 12'd1,  1'b0, res);
    run_op("chain_r5",  1, 5, 4, 1, 1'b0, 12'd0,  1'b0, res);
    run_op("chain_r6",  2, 6, 1, 2, 1'b0, 12'd0,  1'b0, res);
    read_reg("plan_r1", 1, 32'd50);
    read_reg("plan_r2", 2, 32'd60);
    read_reg("plan_r3", 3, 32'd61);
    read_reg("plan_r4", 4, 32'd62);
    read_reg("plan_r5", 5, 32'd12);
    read_reg("plan_r6", 6, 32'd48);
    check_all_regs("chain_all");

    // Writes to r0 are discarded
    run_op("r0_write", 0, 0, 0, 0, 1'b1, 12'd123, 1'b0, res);
    check("r0_write_out", res, 32'd123);
    read_reg("r0_reads_zero", 0, 32'd0);

    // Sign extension and shifts/compares on a negative value
    run_op("sext", 0, 1, 0, 0, 1'b1, 12'hFFF, 1'b0, res);
    run_op("sra",  7, 2, 1, 0, 1'b1, 12'd4, 1'b0, res);
    run_op("srl",  6, 3, 1, 0, 1'b1, 12'd4, 1'b0, res);
    run_op("slt",  8, 4, 1, 0, 1'b0, 12'd0, 1'b0, res);
    run_op("sltu", 9, 5, 1, 0, 1'b0, 12'd0, 1'b0, res);
    read_reg("sext_r1", 1, 32'hFFFF_FFFF);
    read_reg("sra_r2",  2, 32'hFFFF_FFFF);
    read_reg("srl_r3",  3, 32'h0FFF_FFFF);
    read_reg("slt_r4",  4, 32'd1);
    read_reg("sltu_r5", 5, 32'd0);

    // Shift amount uses only B[4:0]; unused op codes yield and write 0
    run_op("ld33", 0, 8, 0, 0, 1'b1, 12'd33, 1'b0, res);
    run_op("ld5",  0, 9, 0, 0, 1'b1, 12'd5,  1'b0, res);
    run_op("sll33", 5, 10, 9, 8, 1'b0, 12'd0, 1'b0, res);
    read_reg("sll33_r10", 10, 32'd10);
    run_op("ld_r11", 0, 11, 0, 0, 1'b1, 12'd7, 1'b0, res);
    for (int unsigned o = 10; o < 16; o++) begin
      run_op("unused_op", o, 11, 1, 8, 1'b0, 12'd0, 1'b0, res);
      check("unused_op_out", res, 32'd0);
    end
    read_reg("unused_op_r11", 11, 32'd0);

    // Mid-stream reset drops the in-flight write
    for (int unsigned r = 1; r <= 5; r++)
      run_op("preload", 0, r, 0, 0, 1'b1, 12'(r * 3 + 1), 1'b0, res);
    run_op("reset_op", 0, 7, 0, 0, 1'b1, 12'd5, 1'b1, res);
    read_reg("reset_r7", 7, 32'd0);
    check_all_regs("after_midreset");

    // Read-during-write returns the old value
    for (int unsigned k = 1; k <= 3; k++) begin
      run_op("rdw", 0, 1, 1, 0, 1'b1, 12'd1, 1'b0, res);
      check("rdw_out", res, 32'(k));
    end
    read_reg("rdw_r1", 1, 32'd3);

    // Randomized ops with occasional reset
    for (int unsigned n = 0; n < 300; n++) begin
      ro   = $urandom_range(0, 15);
      rd   = $urandom_range(0, 31);
      rs1  = $urandom_range(0, 31);
      rs2  = $urandom_range(0, 31);
      rhi  = 1'($urandom_range(0, 1));
      rim  = 12'($urandom);
      rrst = ($urandom_range(0, 49) == 0);
      run_op("rand_op", ro, rd, rs1, rs2, rhi, rim, rrst, res);
    end
    check_all_regs("rand_final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
